branch_predictor_btb: RTL and testbench
=======================================

# branch_predictor_btb

Parametrised dynamic branch predictor for the fetch stage of the pipelined CPU. It replaces static not-taken fetch with a direct-mapped branch target buffer (BTB) carrying per-entry saturating direction counters. Fetch queries it every cycle with the current PC and receives a predicted next PC. Decode, where branches resolve, trains it and reads back a mispredict flag that drives the flush/redirect path. Saturating performance counters record branch and mispredict totals.

## Interface
Parameters:
- PC_WIDTH, 16, width of PC and target fields.
- ENTRIES, 16, BTB depth; power of two, 2..256. IDX_W = log2(ENTRIES).
- CNT_WIDTH, 2, direction counter width; 1..4.
- STAT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_pc  in  PC_WIDTH  current fetch PC.
- next_pc  out  PC_WIDTH  predicted fetch PC for the next cycle.
- pred_taken  out  1  lookup hit and predicted taken.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual branch direction.
- upd_target  in  PC_WIDTH  actual taken target.
- upd_mispredict  out  1  prediction for upd_pc was wrong; combinational.
- clr_stats  in  1  synchronous clear of the performance counters.
- br_count  out  STAT_WIDTH  resolved-branch count.
- mispred_count  out  STAT_WIDTH  mispredict count.

## Operation
- Index is pc[IDX_W:1]; bit 0 is ignored because instructions are halfword-aligned. Tag is pc[PC_WIDTH-1:IDX_W+1].
- Each entry holds: valid, tag, target[PC_WIDTH], and an unsigned counter ctr[CNT_WIDTH].
- A lookup hits when the indexed entry is valid and its tag equals the lookup tag.
- Prediction: pred_taken = hit & ctr[MSB]. next_pc = pred_taken ? target : lookup_pc + 2, truncated to PC_WIDTH, so the PC wraps from all-ones-minus-1 to 0.
- Mispredict, evaluated against current table contents for upd_pc:
  - p = hit(upd_pc) & ctr[MSB].
  - upd_mispredict = upd_valid & ((p != upd_taken) | (p & upd_taken & target != upd_target)).
  - upd_mispredict is 0 whenever upd_valid is 0.
- Training applies only when upd_valid is 1:
  - On a hit, taken: ctr increments, saturating at all-ones; target is rewritten with upd_target.
  - On a hit, not taken: ctr decrements, saturating at 0; target is unchanged.
  - On a miss, taken: allocate the entry. Set valid=1, write tag and target, set ctr to weakly taken (MSB=1, others 0). Any prior occupant is evicted.
  - On a miss, not taken: no state change.
- Performance counters:
  - br_count increments on each upd_valid.
  - mispred_count increments on each upd_mispredict.
  - Both saturate at all-ones.
  - clr_stats forces both to 0 and takes priority over an increment in the same cycle.
- Reset: all valid=0, ctr set to weakly not-taken (MSB=0, others 1), targets and tags 0, both stat counters 0.
- Output values while reset is held: pred_taken=0, next_pc=lookup_pc+2, upd_mispredict=upd_valid&upd_taken, br_count=0, mispred_count=0.

## Timing
- Lookup and upd_mispredict are combinational from the current state and inputs: zero-cycle latency.
- Table and counter writes commit at the rising clk edge following upd_valid.
- A lookup at the same index in the same cycle as an update sees the pre-update entry; there is no bypass.
- A new prediction is visible to a lookup_pc on the cycle after the update edge.
- upd_valid may be asserted every cycle; there is no backpressure and the block never stalls.
- Reset assertion mid-operation clears all state immediately and asynchronously. The first update is accepted at the first rising edge after rst_n deasserts.

## Test plan
- Reset, then lookup_pc=0x0010 -> pred_taken=0, next_pc=0x0012; br_count=0, mispred_count=0.
- Update pc=0x0010, taken, target=0x0040 -> upd_mispredict=1 during that cycle. On the next cycle, lookup 0x0010 -> pred_taken=1, next_pc=0x0040; br_count=1, mispred_count=1.
- Same branch, four not-taken updates (CNT_WIDTH=2) -> counter goes 2→1→0→0. Prediction flips to not-taken after the first update, and the counter holds at 0 with no underflow. mispred_count increments only on the first of the four.
- Aliasing with ENTRIES=16: 0x0010 allocated, then update pc=0x0030 taken target=0x0100 -> lookup 0x0010 misses (next_pc=0x0012); lookup 0x0030 returns 0x0100.
- Lookup 0xFFFE on a miss -> next_pc=0x0000. Lookup and update at the same index in the same cycle -> the lookup returns the old prediction.
- With STAT_WIDTH=4, drive 20 updates -> br_count holds at 0xF. Assert clr_stats together with upd_valid -> br_count=0. Pulse rst_n low mid-stream -> all prior predictions are lost.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch looks up combinationally; decode trains the table and gets
// a combinational mispredict flag back. Two saturating performance counters
// track resolved branches and mispredicts.
module branch_predictor_btb #(
  parameter int PC_WIDTH   = 16,
  parameter int ENTRIES    = 16,
  parameter int CNT_WIDTH  = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic                  pred_taken,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  output logic                  upd_mispredict,
  input  logic                  clr_stats,
  output logic [STAT_WIDTH-1:0] br_count,
  output logic [STAT_WIDTH-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 1;

  localparam logic [CNT_WIDTH-1:0]  CTR_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CTR_WT   = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CTR_WNT  = CTR_WT - CNT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0]   target_q [ENTRIES];
  logic [PC_WIDTH-1:0]   target_d [ENTRIES];
  logic [CNT_WIDTH-1:0]  ctr_q    [ENTRIES];
  logic [CNT_WIDTH-1:0]  ctr_d    [ENTRIES];
  logic [STAT_WIDTH-1:0] br_count_q, br_count_d;
  logic [STAT_WIDTH-1:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, up_pred;

  // Bit 0 of the PC carries no information for halfword-aligned code.
  logic unused_upd_pc_bit0;
  assign unused_upd_pc_bit0 = upd_pc[0];

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[PC_WIDTH-1:IDX_W+1];
  assign up_idx = upd_pc[IDX_W:1];
  assign up_tag = upd_pc[PC_WIDTH-1:IDX_W+1];

  // Fetch-side prediction from the current (pre-update) table contents.
  always_comb begin
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = lk_hit && ctr_q[lk_idx][CNT_WIDTH-1];
    next_pc    = pred_taken ? target_q[lk_idx] : lookup_pc + PC_WIDTH'(2);
  end

  // Decode-side mispredict check against the entry for upd_pc.
  always_comb begin
    up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred        = up_hit && ctr_q[up_idx][CNT_WIDTH-1];
    upd_mispredict = upd_valid &&
                     ((up_pred != upd_taken) ||
                      (up_pred && upd_taken && (target_q[up_idx] != upd_target)));
  end

  // Table training: adjust counter on hit, allocate on taken miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + CNT_WIDTH'(1);
          target_d[up_idx] = upd_target;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - CNT_WIDTH'(1);
        end
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = CTR_WT;
      end
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (clr_stats) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end else begin
      if (upd_valid && (br_count_q != STAT_MAX))
        br_count_d = br_count_q + STAT_WIDTH'(1);
      if (upd_mispredict && (mispred_count_q != STAT_MAX))
        mispred_count_d = mispred_count_q + STAT_WIDTH'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      target_q        <= target_d;
      ctr_q           <= ctr_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb (ENTRIES=16, CNT_WIDTH=2,
// STAT_WIDTH=4). Stimulus pushes hand-computed expectations; a negedge
// monitor pops and compares them against the DUT outputs.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lookup_pc;
  logic [15:0] next_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_mispredict;
  logic        clr_stats;
  logic [3:0]  br_count;
  logic [3:0]  mispred_count;

  branch_predictor_btb #(
    .PC_WIDTH  (16),
    .ENTRIES   (16),
    .CNT_WIDTH (2),
    .STAT_WIDTH(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (lookup_pc),
    .next_pc       (next_pc),
    .pred_taken    (pred_taken),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .clr_stats     (clr_stats),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  typedef enum int {S_NPC, S_PRED, S_MISP, S_BR, S_MIS} sel_e;
  typedef struct {
    sel_e        sel;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every mid-cycle, compare all expectations queued this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        S_NPC:   act = next_pc;
        S_PRED:  act = {15'b0, pred_taken};
        S_MISP:  act = {15'b0, upd_mispredict};
        S_BR:    act = {12'b0, br_count};
        default: act = {12'b0, mispred_count};
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h", e.name, act, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                       input logic ut, input logic [15:0] utg, input logic clr);
    lookup_pc  = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utg;
    clr_stats  = clr;
  endtask

  task automatic push(input sel_e s, input logic [15:0] v, input string nm);
    exp_t e;
    e.sel  = s;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic exp_lk(input logic p, input logic [15:0] npc, input string nm);
    push(S_PRED, {15'b0, p}, {nm, "_pred"});
    push(S_NPC, npc, {nm, "_npc"});
  endtask

  task automatic exp_st(input int br, input int mis, input string nm);
    push(S_BR, 16'(br), {nm, "_br"});
    push(S_MIS, 16'(mis), {nm, "_mis"});
  endtask

  task automatic exp_mp(input logic m, input string nm);
    push(S_MISP, {15'b0, m}, {nm, "_misp"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    tick();
    // Reset held: update not accepted, flag follows upd_taken.
    exp_lk(1'b0, 16'h0012, "rst"); exp_mp(1'b1, "rst"); exp_st(0, 0, "rst");
    tick();
    rst_n = 1'b1;
    drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b0, 16'h0012, "c1"); exp_mp(1'b0, "c1"); exp_st(0, 0, "c1");
    tick();
    // Allocate 0x0010 -> 0x0040; same-cycle lookup sees old state.
    drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    exp_mp(1'b1, "c2"); exp_lk(1'b0, 16'h0012, "c2"); exp_st(0, 0, "c2");
    tick();
    drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b1, 16'h0040, "c3"); exp_st(1, 1, "c3");
    tick();
    // Four not-taken updates: ctr 2->1->0->0.
    drive(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
    exp_mp(1'b1, "nt1"); exp_lk(1'b1, 16'h0040, "nt1"); exp_st(1, 1, "nt1");
    tick();
    exp_mp(1'b0, "nt2"); exp_lk(1'b0, 16'h0012, "nt2"); exp_st(2, 2, "nt2");
    tick();
    exp_mp(1'b0, "nt3"); exp_st(3, 2, "nt3");
    tick();
    exp_mp(1'b0, "nt4"); exp_st(4, 2, "nt4");
    tick();
    // Counter must be at 0: taken update still predicted not-taken.
    drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
    exp_mp(1'b1, "uflow"); exp_lk(1'b0, 16'h0012, "uflow"); exp_st(5, 2, "uflow");
    tick();
    exp_mp(1'b1, "ctr1"); exp_lk(1'b0, 16'h0012, "ctr1"); exp_st(6, 3, "ctr1");
    tick();
    // ctr=2, predicted taken but target differs.
    drive(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0044, 1'b0);
    exp_mp(1'b1, "tgt"); exp_lk(1'b1, 16'h0040, "tgt"); exp_st(7, 4, "tgt");
    tick();
    exp_mp(1'b0, "sat3"); exp_lk(1'b1, 16'h0044, "sat3"); exp_st(8, 5, "sat3");
    tick();
    // ctr saturated at 3; one not-taken leaves it at 2 (still taken).
    drive(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
    exp_mp(1'b1, "dec"); exp_lk(1'b1, 16'h0044, "dec"); exp_st(9, 5, "dec");
    tick();
    drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b1, 16'h0044, "nosat"); exp_st(10, 6, "nosat");
    tick();
    // Alias 0x0030 onto index 8 with a different tag.
    drive(16'h0030, 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0);
    exp_mp(1'b1, "alias"); exp_lk(1'b0, 16'h0032, "alias"); exp_st(10, 6, "alias");
    tick();
    drive(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b0, 16'h0012, "evict"); exp_st(11, 7, "evict");
    tick();
    drive(16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b1, 16'h0100, "newent");
    tick();
    // PC wrap on miss; miss-not-taken update changes nothing.
    drive(16'hFFFE, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b0, 16'h0000, "wrap"); exp_mp(1'b0, "wrap"); exp_st(11, 7, "wrap");
    tick();
    drive(16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b0, 16'h0004, "nostate"); exp_st(12, 7, "nostate");
    tick();
    // br_count saturates at 0xF.
    for (int i = 0; i < 6; i++) begin
      drive(16'h0030, 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0);
      exp_mp(1'b0, $sformatf("bsat%0d", i));
      exp_st((12 + i > 15) ? 15 : 12 + i, 7, $sformatf("bsat%0d", i));
      tick();
    end
    // Clear together with a mispredicting update: clear wins.
    drive(16'h0050, 1'b1, 16'h0050, 1'b1, 16'h0200, 1'b1);
    exp_mp(1'b1, "clr"); exp_st(15, 7, "clr");
    tick();
    // Taken updates with changing targets all mispredict; mispred saturates.
    for (int i = 0; i < 17; i++) begin
      drive(16'h0050, 1'b1, 16'h0050, 1'b1, (i % 2 == 0) ? 16'h0300 : 16'h0400, 1'b0);
      exp_mp(1'b1, $sformatf("msat%0d", i));
      exp_st((i > 15) ? 15 : i, (i > 15) ? 15 : i, $sformatf("msat%0d", i));
      tick();
    end
    drive(16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b1, 16'h0300, "prerst"); exp_st(15, 15, "prerst");
    tick();
    // Mid-stream reset drops all state asynchronously.
    rst_n = 1'b0;
    drive(16'h0050, 1'b1, 16'h0050, 1'b1, 16'h0300, 1'b0);
    exp_lk(1'b0, 16'h0052, "midrst"); exp_mp(1'b1, "midrst"); exp_st(0, 0, "midrst");
    tick();
    rst_n = 1'b1;
    drive(16'h0030, 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0);
    exp_lk(1'b0, 16'h0032, "lost30"); exp_mp(1'b1, "lost30"); exp_st(0, 0, "lost30");
    tick();
    drive(16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b1, 16'h0100, "postrst"); exp_st(1, 1, "postrst");
    tick();
    drive(16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    exp_lk(1'b0, 16'h0052, "lost50");
    tick();
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
